branch_predict_resolve: RTL
===========================

Name: branch_predict_resolve

Overview:
- Parametrised successor to the MEM-stage branch resolution unit.
- Adds a PC-indexed branch history table (BHT) of saturating counters.
  - The IF stage reads it for a taken/not-taken prediction.
  - The MEM stage updates it on branch resolution.
- Redirect and pipeline flush now happen only on misprediction or JAL/JALR, not on every taken branch.
- Saturating statistics counters for performance monitoring.

Parameters:
- XLEN, 32, PC/target width.
- BHT_ENTRIES, 64, number of BHT entries; power of two, >= 2.
- CTR_BITS, 2, width of each saturating counter; >= 1.
- STAT_WIDTH, 32, width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- if_pc  in  XLEN  PC of the instruction being fetched.
- if_pred_taken  out  1  prediction for if_pc; combinational read of the BHT.
- mem_valid  in  1  MEM stage holds a valid, non-stalled instruction.
- mem_branch  in  1  instruction is a conditional branch.
- mem_jalx  in  1  instruction is JAL/JALR.
- mem_alu_taken  in  1  ALU branch condition result.
- mem_pred_taken  in  1  prediction carried down the pipe with this instruction.
- mem_pc  in  XLEN  PC of the MEM-stage instruction.
- mem_target  in  XLEN  computed branch/jump target.
- pcsrc  out  1  redirect the fetch PC to redirect_pc.
- redirect_pc  out  XLEN  corrected fetch address.
- ifflush  out  1  flush the IF/ID register.
- idflush  out  1  flush the ID/EX register.
- exflush  out  1  flush the EX/MEM register.
- stat_clr  in  1  synchronous clear of the statistics counters.
- stat_branches  out  STAT_WIDTH  count of resolved conditional branches.
- stat_mispredicts  out  STAT_WIDTH  count of mispredicted conditional branches.

Behaviour:
- Index:
  - IDX = log2(BHT_ENTRIES).
  - Lookup index = if_pc[IDX+1:2].
  - Update index = mem_pc[IDX+1:2].
- Prediction: if_pred_taken = MSB of the indexed counter. Purely combinational, zero latency.
- Reset (rst low, asynchronous):
  - Every BHT counter = 2^(CTR_BITS-1)-1 (weakly not-taken; 01 for CTR_BITS=2).
  - Both statistics counters = 0.
  - While rst is low, pcsrc/ifflush/idflush/exflush = 0 regardless of inputs.
  - Reset asserted mid-operation discards any update for that edge.
- Resolution is gated by mem_valid. With mem_valid=0, all control outputs are 0 and no state changes.
- Misprediction: mispredict = mem_valid & mem_branch & (mem_alu_taken != mem_pred_taken).
- Redirect: redirect = (mem_valid & mem_jalx) | mispredict.
  - pcsrc = ifflush = idflush = exflush = redirect, combinational, same cycle.
- redirect_pc:
  - mem_target if mem_jalx, or if mispredict with mem_alu_taken=1.
  - mem_pc+4 (mod 2^XLEN) if mispredict with mem_alu_taken=0.
  - Don't-care (drive mem_target) when redirect=0.
- BHT update on the clock edge, when mem_valid & mem_branch:
  - Increment the counter if mem_alu_taken, decrement otherwise.
  - Saturate at all-ones and at 0.
  - JAL/JALR do not update the BHT.
- Same-cycle read and update of the same entry:
  - if_pred_taken reflects the pre-update value; no bypass.
  - The new value is visible from the next cycle.
- mem_branch and mem_jalx both set: illegal; treat as mem_jalx (redirect to mem_target, no BHT update).
- Statistics counters:
  - stat_branches increments on valid conditional-branch resolution.
  - stat_mispredicts increments on mispredict.
  - Both saturate at all-ones.
  - stat_clr has priority over an increment in the same cycle.

Decomposition:
- Shared package holds:
  - BHT reset value constant.
  - Counter saturation limits.
  - IDX computation function.
  - The 4-byte instruction size constant.
- One natural sub-module: bht_sat_counter_array.
  - Parametrised by depth and width.
  - One combinational read port, one synchronous saturating inc/dec write port, asynchronous active-low reset.
- Redirect and flush logic stays in the top.

Test Plan:
- Reset then read any PC:
  - if_pred_taken=0.
  - Two taken resolutions at mem_pc=0x100 make the next read of if_pc=0x100 return 1.
  - if_pc=0x200 (same index with 64 entries) also returns 1: aliasing.
- Correct prediction (mem_pred_taken=1, mem_alu_taken=1, mem_branch=1, mem_valid=1):
  - pcsrc=0 and all flushes 0.
  - stat_branches +1, stat_mispredicts unchanged.
- Predicted taken, actually not taken, mem_pc=0x80:
  - pcsrc=1, redirect_pc=0x84, all three flushes 1.
  - stat_mispredicts +1.
- mem_jalx=1, mem_target=0x4000:
  - pcsrc=1, redirect_pc=0x4000.
  - BHT and statistics unchanged.
- Saturation:
  - Five taken updates on one entry leave the counter at 3; five not-taken updates leave it at 0.
  - stat_clr together with an increment leaves the counter at 0.
- Assert rst low in the same cycle as a mispredicting resolution:
  - All outputs 0 immediately.
  - BHT back to 01 everywhere, statistics 0.

Source files
------------

// File: rtl/branch_predict_resolve_pkg.sv
// Shared constants and sizing helpers for the MEM-stage branch resolver and its
// branch history table.
package branch_predict_resolve_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int CTR_MIN     = 0;

  function automatic int idx_bits(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int ctr_max(input int ctr_bits);
    return (1 << ctr_bits) - 1;
  endfunction

  // Weakly not-taken: the largest value whose MSB is still clear.
  function automatic int ctr_reset(input int ctr_bits);
    return (1 << (ctr_bits - 1)) - 1;
  endfunction

endpackage

// File: rtl/bht_sat_counter_array.sv
// Array of saturating up/down counters with one combinational read port and
// one synchronous inc/dec write port.
module bht_sat_counter_array
  import branch_predict_resolve_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [idx_bits(DEPTH)-1:0] rd_idx,
  output logic [WIDTH-1:0]           rd_ctr,
  input  logic                       wr_en,
  input  logic                       wr_inc,
  input  logic [idx_bits(DEPTH)-1:0] wr_idx
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(ctr_reset(WIDTH));
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(ctr_max(WIDTH));
  localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(CTR_MIN);

  logic [WIDTH-1:0] ctr [DEPTH];

  function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] c,
                                                input logic inc);
    if (inc)
      return (c == MAX_VAL) ? c : c + 1'b1;
    return (c == MIN_VAL) ? c : c - 1'b1;
  endfunction

  // Read sees the pre-update value when read and write hit the same entry.
  assign rd_ctr = ctr[rd_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        ctr[i] <= RST_VAL;
    end else if (wr_en) begin
      ctr[wr_idx] <= sat_step(ctr[wr_idx], wr_inc);
    end
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// MEM-stage branch resolution with a PC-indexed BHT: redirects and flushes only
// on misprediction or JAL/JALR, and keeps saturating branch statistics.
module branch_predict_resolve
  import branch_predict_resolve_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int STAT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       if_pc,
  output logic                  if_pred_taken,
  input  logic                  mem_valid,
  input  logic                  mem_branch,
  input  logic                  mem_jalx,
  input  logic                  mem_alu_taken,
  input  logic                  mem_pred_taken,
  input  logic [XLEN-1:0]       mem_pc,
  input  logic [XLEN-1:0]       mem_target,
  output logic                  pcsrc,
  output logic [XLEN-1:0]       redirect_pc,
  output logic                  ifflush,
  output logic                  idflush,
  output logic                  exflush,
  input  logic                  stat_clr,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  localparam int IDX = idx_bits(BHT_ENTRIES);

  logic [CTR_BITS-1:0] rd_ctr;
  logic                is_branch;
  logic                mispredict;
  logic                redirect;
  logic                unused_if_pc_bits;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A JAL/JALR that also claims to be a branch is resolved purely as a jump.
  assign is_branch  = mem_valid & mem_branch & ~mem_jalx;
  assign mispredict = is_branch & (mem_alu_taken ^ mem_pred_taken);
  assign redirect   = rst & ((mem_valid & mem_jalx) | mispredict);

  assign pcsrc   = redirect;
  assign ifflush = redirect;
  assign idflush = redirect;
  assign exflush = redirect;

  assign redirect_pc = (mispredict & ~mem_alu_taken) ? mem_pc + XLEN'(INSTR_BYTES)
                                                     : mem_target;

  assign if_pred_taken     = rd_ctr[CTR_BITS-1];
  assign unused_if_pc_bits = ^{if_pc[XLEN-1:IDX+2], if_pc[1:0]};

  bht_sat_counter_array #(
    .DEPTH (BHT_ENTRIES),
    .WIDTH (CTR_BITS)
  ) u_bht (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (if_pc[IDX+1:2]),
    .rd_ctr (rd_ctr),
    .wr_en  (is_branch),
    .wr_inc (mem_alu_taken),
    .wr_idx (mem_pc[IDX+1:2])
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (stat_clr) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (is_branch)
        stat_branches <= sat_inc(stat_branches);
      if (mispredict)
        stat_mispredicts <= sat_inc(stat_mispredicts);
    end
  end

endmodule
